freq_link_sched: RTL
====================

// Module: freq_link_sched
// PURPOSE
//   Half-duplex link scheduler for the shared frequency encoder/decoder channel.
//   Serialises a byte into timed per-bit windows that drive the encoder's data
//   and enable inputs.
//   Between frames, it hunts for incoming pulses and decodes 8 pulse-count
//   windows into a received byte.
//   Arbitrates TX versus RX on the single channel; RX wins because an incoming
//   frame cannot be deferred.
// PARAMETERS
//   BIT_CYCLES  1000  clk cycles per bit window (TX and RX), >=2
//   GAP_CYCLES  100   guard cycles after every frame; channel idle, input ignored
//   THRESH      8     RX bit = 1 when the window edge count >= THRESH
//   CNT_W       8     width of the RX edge counter; saturates at 2^CNT_W-1
// PORTS
//   clk       in   1   single clock
//   reset     in   1   synchronous, active-high reset
//   tx_valid  in   1   TX byte request
//   tx_data   in   8   byte to send, LSB first
//   tx_ready  out  1   combinational: (state==IDLE) && !edge
//   enc_bit   out  1   bit value presented to the encoder data input
//   enc_en    out  1   encoder enable; high only during TX_BIT
//   pulse_in  in   1   raw pulse line from the channel (asynchronous)
//   rx_valid  out  1   one-cycle strobe; rx_data valid while it is high
//   rx_data   out  8   last received byte; held until the next strobe
//   busy      out  1   state != IDLE
//   col_err   out  1   one-cycle strobe: pulse edge seen during TX_BIT
// BEHAVIOUR
//   Reset (sync, any state):
//     - state=IDLE; all counters=0.
//     - enc_bit, enc_en, rx_valid, col_err, busy = 0; rx_data = 8'h00.
//     - Sync flops and edge history cleared, so no spurious edge after release.
//     - A frame in progress is dropped silently; nothing is reported.
//   pulse_in path: 2-FF synchroniser, then edge = sync & ~prev.
//     - Edge latency is 3 clk from the pulse_in rise.
//   IDLE:
//     - If edge: go to RX_BIT, bit_idx=0, cyc=0, cnt=0. The start edge itself
//       is not counted.
//     - Else if tx_valid (tx_ready=1): latch tx_data, go to TX_BIT, bit_idx=0.
//     - Edge and tx_valid in the same cycle: RX wins, tx_ready=0, request not
//       taken; requester must hold tx_valid.
//   TX_BIT:
//     - enc_en=1, enc_bit=shreg[0].
//     - At cyc==BIT_CYCLES-1: shift the register, bit_idx++, cyc=0.
//     - After bit 7: go to GAP.
//     - Window bit0 starts the cycle after acceptance; the frame spans
//       8*BIT_CYCLES cycles.
//     - edge -> col_err=1 for that cycle; TX continues unaltered.
//     - tx_valid is ignored (tx_ready=0).
//   RX_BIT:
//     - Count edges in the window; cnt saturates.
//     - At cyc==BIT_CYCLES-1: bit = (cnt + edge_this_cycle) >= THRESH, so an
//       edge in the final cycle counts.
//     - Bit is shifted in LSB first; cnt=0; bit_idx++.
//     - After bit 7: rx_data updates and rx_valid=1 on the first GAP cycle.
//   GAP:
//     - enc_en=0; edges are ignored and not counted.
//     - After GAP_CYCLES cycles, return to IDLE.
//   Width rules:
//     - cyc sized for clog2(max(BIT_CYCLES,GAP_CYCLES)).
//     - bit_idx is 3 bits; the window ends on bit_idx==7, with no wrap.
//     - THRESH is compared at CNT_W+1 bits so it never overflows.
// STRUCTURE
//   freq_pkg.vh:
//     - State encodings IDLE/TX_BIT/RX_BIT/GAP (2-bit localparams).
//     - Shared BIT_CYCLES/THRESH defaults, for use with encoder/decoder configs.
//   Sub-module freq_pulse_sync: 2-FF sync + edge detect; ports clk, reset, d, edge.
//   Top: one FSM, one shared cycle counter, one shift register reused for TX
//   and RX (half-duplex).
// TESTING (BIT_CYCLES=16, GAP_CYCLES=4, THRESH=4)
//   1. TX 0xA5 accepted at cycle T:
//      - enc_en high for cycles T+1..T+128.
//      - enc_bit = 1,0,1,0,0,1,0,1 in 16-cycle blocks.
//      - busy until T+132; tx_ready=1 at T+133.
//   2. RX 0x3C: after a start edge, drive 6 edges in each 1-window and 1 edge in
//      each 0-window -> single rx_valid, rx_data=0x3C.
//   3. Threshold: windows with 4 edges decode as 1 and with 3 edges as 0.
//      A 4th edge landing on the final window cycle still decodes as 1.
//   4. Same-cycle tx_valid(0x81) and edge in IDLE:
//      - RX starts and tx_ready=0.
//      - 0x81 is accepted on the first IDLE cycle after GAP.
//   5. Edge mid-TX:
//      - col_err is exactly 1 cycle.
//      - enc_bit sequence is identical to the clean run; no rx_valid.
//   6. reset held 2 cycles mid-RX (bit 3):
//      - All outputs 0 and rx_data=0 next cycle.
//      - No rx_valid afterwards; busy=0; tx_ready=1 after release.

Source files
------------

// File: rtl/freq_link_sched_pkg.sv
// rtl/freq_link_sched_pkg.sv - shared states, defaults and sizing helper for the link scheduler
package freq_link_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TX_BIT = 2'd1,
    ST_RX_BIT = 2'd2,
    ST_GAP    = 2'd3
  } link_state_e;

  // Defaults kept here so encoder/decoder configs can share the same timing.
  localparam int DEF_BIT_CYCLES = 1000;
  localparam int DEF_GAP_CYCLES = 100;
  localparam int DEF_THRESH     = 8;
  localparam int DEF_CNT_W      = 8;

  // One counter serves both bit windows and the guard gap.
  function automatic int cyc_width(input int bit_cycles, input int gap_cycles);
    int m;
    m = (bit_cycles > gap_cycles) ? bit_cycles : gap_cycles;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/freq_pulse_sync.sv
// rtl/freq_pulse_sync.sv - two-flop synchroniser with rising-edge detect for the raw pulse line
module freq_pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_link_sched.sv
// rtl/freq_link_sched.sv - half-duplex TX/RX scheduler for the shared frequency channel
module freq_link_sched
  import freq_link_sched_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int THRESH     = DEF_THRESH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       enc_bit,
  output logic       enc_en,
  input  logic       pulse_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       col_err
);

  localparam int CYC_W  = cyc_width(BIT_CYCLES, GAP_CYCLES);
  localparam int CNT_W1 = CNT_W + 1;
  localparam logic [CYC_W-1:0]  BIT_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0]  GAP_LAST = CYC_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W:0]    THRESH_W = CNT_W1'(THRESH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  link_state_e      state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;

  logic             edge_w;
  logic [CNT_W:0]   rx_total;
  logic             rx_bit;
  logic             win_end;

  freq_pulse_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (pulse_in),
    .edge_o (edge_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // An edge on the last window cycle still contributes to that window's decision.
  assign rx_total = {1'b0, cnt_q} + CNT_W1'(edge_w);
  assign rx_bit   = (rx_total >= THRESH_W);
  assign win_end  = (cyc_q == BIT_LAST);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // RX has priority: an incoming frame cannot be deferred, a TX request can.
        if (edge_w) begin
          state_d   = ST_RX_BIT;
          cyc_d     = '0;
          bit_idx_d = '0;
          cnt_d     = '0;
        end else if (tx_valid) begin
          state_d   = ST_TX_BIT;
          shreg_d   = tx_data;
          cyc_d     = '0;
          bit_idx_d = '0;
        end
      end

      ST_TX_BIT: begin
        if (win_end) begin
          cyc_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = ST_GAP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      ST_RX_BIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(edge_w);
        end
        if (win_end) begin
          cyc_d   = '0;
          cnt_d   = '0;
          shreg_d = {rx_bit, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d  = '0;
            state_d    = ST_GAP;
            rx_data_d  = {rx_bit, shreg_q[7:1]};
            rx_valid_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  assign tx_ready = (state_q == ST_IDLE) && !edge_w;
  assign enc_en   = (state_q == ST_TX_BIT);
  assign enc_bit  = (state_q == ST_TX_BIT) && shreg_q[0];
  assign col_err  = (state_q == ST_TX_BIT) && edge_w;
  assign busy     = (state_q != ST_IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule
